// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - loadable down-counter with terminal-count pulse and auto-reload
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] reload_reg;
  logic             load_fire;
  logic             at_one;
  logic             at_zero;

  assign load_fire = load_valid && load_ready;
  assign at_one    = (count == WIDTH'(1));
  assign at_zero   = (count == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode; a load always wins over start, stop wins over start/en
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (load_fire) state_nx = ARMED;
      end
      ARMED: begin
        if (load_fire) begin
          state_nx = ARMED;
        end else if (start && !stop) begin
          state_nx = at_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nx = ARMED;
        end else if (en && (at_zero || (at_one && !auto_reload))) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (load_fire) state_nx = ARMED;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    load_ready = (state != RUN);
    busy       = (state == RUN);
  end

  // Count, reload period, terminal-count pulse and sticky error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= '0;
      reload_reg <= '0;
      tc         <= 1'b0;
      err        <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load_fire) begin
        count      <= load_value;
        reload_reg <= load_value;
        err        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) err <= 1'b1;
          end
          ARMED: begin
            // Starting an already-expired period fires immediately
            if (start && !stop && at_zero) tc <= 1'b1;
          end
          RUN: begin
            if (!stop && en) begin
              if (at_one) begin
                tc    <= 1'b1;
                count <= auto_reload ? reload_reg : '0;
              end else if (!at_zero) begin
                count <= count - WIDTH'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed and randomized checks of countdown_timer against a reference model
module tb_countdown_timer;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             stop;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             err;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .en         (en),
    .auto_reload(auto_reload),
    .count      (count),
    .busy       (busy),
    .tc         (tc),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int tc_seen  = 0;

  // Reference model: a value is held or not, counting or not, expired or not
  bit m_has_value;
  bit m_counting;
  bit m_expired;
  int m_count;
  int m_period;
  bit m_tc;
  bit m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_has_value = 0; m_counting = 0; m_expired = 0;
    m_count = 0; m_period = 0; m_tc = 0; m_err = 0;
  endtask

  task automatic model_step();
    m_tc = 0;
    if (load_valid && !m_counting) begin
      m_count = int'(load_value); m_period = int'(load_value);
      m_err = 0; m_has_value = 1; m_expired = 0;
    end else if (m_counting) begin
      if (stop) m_counting = 0;
      else if (en) begin
        if (m_count == 1) begin
          m_tc = 1;
          if (auto_reload) m_count = m_period;
          else begin m_count = 0; m_counting = 0; m_expired = 1; end
        end else if (m_count > 1) m_count = m_count - 1;
      end
    end else if (m_has_value && !m_expired) begin
      if (start && !stop) begin
        if (m_count == 0) begin m_expired = 1; m_tc = 1; end
        else m_counting = 1;
      end
    end else if (!m_has_value) begin
      if (start) m_err = 1;
    end
  endtask

  task automatic compare_all();
    check("count", 32'(count), 32'(m_count));
    check("tc", 32'(tc), 32'(m_tc));
    check("busy", 32'(busy), 32'(m_counting));
    check("load_ready", 32'(load_ready), 32'(!m_counting));
    check("err", 32'(err), 32'(m_err));
  endtask

  // One clock: predict, advance past the edge, compare
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    if (tc === 1'b1) tc_seen++;
    compare_all();
  endtask

  task automatic quiet();
    load_valid = 0; start = 0; stop = 0; en = 0;
  endtask

  task automatic do_load(input int v);
    quiet();
    load_valid = 1; load_value = WIDTH'(v);
    cyc();
    load_valid = 0;
  endtask

  task automatic do_start();
    start = 1; cyc(); start = 0;
  endtask

  task automatic async_reset();
    #2 rst = 1;
    #1;
    model_reset();
    check("rst_count", 32'(count), 32'd0);
    check("rst_tc", 32'(tc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd1);
    #1 rst = 0;
  endtask

  initial begin
    rst = 1; quiet(); auto_reload = 0; load_value = '0;
    model_reset();
    #12;
    compare_all();
    check("reset_count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;

    // 1) one-shot load 5
    do_load(5);
    do_start();
    en = 1; tc_seen = 0;
    for (int i = 0; i < 7; i++) cyc();
    check("t1_tc_pulses", 32'(tc_seen), 32'd1);
    check("t1_done_ready", 32'(load_ready), 32'd1);

    // 2) auto-reload period 3
    auto_reload = 1;
    do_load(3);
    do_start();
    en = 1; tc_seen = 0;
    for (int i = 0; i < 9; i++) cyc();
    check("t2_tc_pulses", 32'(tc_seen), 32'd3);
    stop = 1; cyc(); stop = 0; auto_reload = 0;

    // 3) en toggling, load 10
    do_load(10);
    do_start();
    tc_seen = 0;
    for (int i = 0; i < 24; i++) begin en = (i % 2 == 0); cyc(); end
    check("t3_tc_pulses", 32'(tc_seen), 32'd1);
    en = 0;

    // 4) stop beats start; loads ignored while running
    do_load(8);
    do_start();
    en = 1;
    for (int i = 0; i < 3; i++) cyc();
    load_valid = 1; load_value = 8'd99; cyc(); load_valid = 0;
    stop = 1; start = 1; cyc(); stop = 0; start = 0;
    check("t4_paused_count", 32'(count), 32'd4);
    en = 1; cyc(); cyc();
    do_start();
    en = 1;
    for (int i = 0; i < 6; i++) cyc();

    // 5) start in IDLE sets err; load 0 then start
    async_reset();
    quiet(); start = 1; cyc(); start = 0;
    check("t5_err", 32'(err), 32'd1);
    do_load(0);
    tc_seen = 0;
    do_start();
    cyc(); cyc();
    check("t5_tc_once", 32'(tc_seen), 32'd1);

    // 6) async reset mid-run at count 4
    do_load(6);
    do_start();
    en = 1; cyc(); cyc();
    check("t6_pre_count", 32'(count), 32'd4);
    async_reset();
    quiet(); cyc();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      load_valid  = ($urandom_range(0, 7) == 0);
      load_value  = ($urandom_range(0, 9) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 6));
      start       = ($urandom_range(0, 3) == 0);
      stop        = ($urandom_range(0, 11) == 0);
      en          = ($urandom_range(0, 3) != 0);
      auto_reload = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 499) == 0) async_reset();
      else cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
